// File: rtl/ctrl_resp_router.sv
// Routes one host control stream to NUM_CHAN endpoints by masked SID and merges
// their responses with packet-level round-robin; unmatched packets are dropped and counted.
module ctrl_resp_router #(
    parameter int                    NUM_CHAN = 4,
    parameter int                    WIDTH    = 64,
    parameter logic [7:0]            SID_MASK = 8'hF0,
    parameter logic [NUM_CHAN*8-1:0] SID_LIST = {8'h40, 8'h30, 8'h10, 8'h50},
    parameter int                    CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic [WIDTH-1:0]          ctrl_tdata,
    input  logic                      ctrl_tlast,
    input  logic                      ctrl_tvalid,
    output logic                      ctrl_tready,
    output logic [NUM_CHAN*WIDTH-1:0] o_tdata,
    output logic [NUM_CHAN-1:0]       o_tlast,
    output logic [NUM_CHAN-1:0]       o_tvalid,
    input  logic [NUM_CHAN-1:0]       o_tready,
    input  logic [NUM_CHAN*WIDTH-1:0] r_tdata,
    input  logic [NUM_CHAN-1:0]       r_tlast,
    input  logic [NUM_CHAN-1:0]       r_tvalid,
    output logic [NUM_CHAN-1:0]       r_tready,
    output logic [WIDTH-1:0]          resp_tdata,
    output logic                      resp_tlast,
    output logic                      resp_tvalid,
    input  logic                      resp_tready,
    output logic [CNT_W-1:0]          drop_count,
    output logic                      demux_busy
);

    localparam int IDX_W = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;

    typedef enum logic [1:0] {D_IDLE, D_FWD, D_DROP} dstate_t;
    typedef enum logic       {A_IDLE, A_GRANT}       astate_t;

    dstate_t            d_state_q, d_state_d;
    logic [IDX_W-1:0]   dest_q, dest_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    astate_t            a_state_q, a_state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;

    logic               hit;
    logic [IDX_W-1:0]   hit_idx;
    logic               pick_vld;
    logic [IDX_W-1:0]   pick;

    // Every endpoint sees the same data; only its valid qualifies it.
    assign o_tdata    = {NUM_CHAN{ctrl_tdata}};
    assign drop_count = cnt_q;
    assign demux_busy = (d_state_q != D_IDLE);

    // Descending scan so the lowest matching channel is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = NUM_CHAN - 1; k >= 0; k--) begin
            if ((ctrl_tdata[7:0] & SID_MASK) == (SID_LIST[8*k +: 8] & SID_MASK)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(k);
            end
        end
    end

    always_comb begin
        d_state_d   = d_state_q;
        dest_d      = dest_q;
        cnt_d       = cnt_q;
        ctrl_tready = 1'b0;
        o_tvalid    = '0;
        o_tlast     = '0;
        case (d_state_q)
            D_IDLE: begin
                if (ctrl_tvalid) begin
                    if (hit) begin
                        dest_d    = hit_idx;
                        d_state_d = D_FWD;
                    end else begin
                        d_state_d = D_DROP;
                        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            D_FWD: begin
                o_tvalid[dest_q] = ctrl_tvalid;
                o_tlast[dest_q]  = ctrl_tlast;
                ctrl_tready      = o_tready[dest_q];
                if (ctrl_tvalid && o_tready[dest_q] && ctrl_tlast) d_state_d = D_IDLE;
            end
            D_DROP: begin
                ctrl_tready = 1'b1;
                if (ctrl_tvalid && ctrl_tlast) d_state_d = D_IDLE;
            end
            default: d_state_d = D_IDLE;
        endcase
    end

    // Round-robin search starting just after the last completed grant.
    always_comb begin
        int idx;
        pick_vld = 1'b0;
        pick     = '0;
        for (int i = 1; i <= NUM_CHAN; i++) begin
            idx = (int'(last_grant_q) + i) % NUM_CHAN;
            if (!pick_vld && r_tvalid[idx]) begin
                pick_vld = 1'b1;
                pick     = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        a_state_d    = a_state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        r_tready     = '0;
        resp_tvalid  = 1'b0;
        resp_tlast   = 1'b0;
        resp_tdata   = '0;
        case (a_state_q)
            A_IDLE: begin
                if (pick_vld) begin
                    grant_d   = pick;
                    a_state_d = A_GRANT;
                end
            end
            A_GRANT: begin
                resp_tdata        = r_tdata[int'(grant_q)*WIDTH +: WIDTH];
                resp_tlast        = r_tlast[grant_q];
                resp_tvalid       = r_tvalid[grant_q];
                r_tready[grant_q] = resp_tready;
                if (r_tvalid[grant_q] && resp_tready && r_tlast[grant_q]) begin
                    last_grant_d = grant_q;
                    a_state_d    = A_IDLE;
                end
            end
            default: a_state_d = A_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_state_q    <= D_IDLE;
            dest_q       <= '0;
            cnt_q        <= '0;
            a_state_q    <= A_IDLE;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(NUM_CHAN - 1);
        end else if (clear) begin
            d_state_q    <= D_IDLE;
            dest_q       <= '0;
            cnt_q        <= '0;
            a_state_q    <= A_IDLE;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(NUM_CHAN - 1);
        end else begin
            d_state_q    <= d_state_d;
            dest_q       <= dest_d;
            cnt_q        <= cnt_d;
            a_state_q    <= a_state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_ctrl_resp_router.sv
// Scoreboard bench for ctrl_resp_router: stimulus pushes expected beats, monitors pop on handshakes.
module tb_ctrl_resp_router;

    localparam int NC = 4;
    localparam int W  = 64;
    localparam int CW = 4;
    // Channel k SID sits at bits [8k+7:8k]: ch0=0x40, ch1=0x30, ch2=0x10, ch3=0x50.
    localparam logic [31:0] SIDS = {8'h50, 8'h10, 8'h30, 8'h40};

    logic              clk, reset, clear;
    logic [W-1:0]      ctrl_tdata;
    logic              ctrl_tlast, ctrl_tvalid, ctrl_tready;
    logic [NC*W-1:0]   o_tdata;
    logic [NC-1:0]     o_tlast, o_tvalid, o_tready;
    logic [NC*W-1:0]   r_tdata;
    logic [NC-1:0]     r_tlast, r_tvalid, r_tready;
    logic [W-1:0]      resp_tdata;
    logic              resp_tlast, resp_tvalid, resp_tready;
    logic [CW-1:0]     drop_count;
    logic              demux_busy;

    logic [NC-1:0]     o_tready_m;
    logic              rnd_en, rnd_rdy;
    assign o_tready = {o_tready_m[NC-1:1], rnd_en ? rnd_rdy : o_tready_m[0]};

    ctrl_resp_router #(
        .NUM_CHAN(NC), .WIDTH(W), .SID_MASK(8'hF0), .SID_LIST(SIDS), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .ctrl_tdata(ctrl_tdata), .ctrl_tlast(ctrl_tlast),
        .ctrl_tvalid(ctrl_tvalid), .ctrl_tready(ctrl_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
        .r_tdata(r_tdata), .r_tlast(r_tlast), .r_tvalid(r_tvalid), .r_tready(r_tready),
        .resp_tdata(resp_tdata), .resp_tlast(resp_tlast),
        .resp_tvalid(resp_tvalid), .resp_tready(resp_tready),
        .drop_count(drop_count), .demux_busy(demux_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [68:0] exp_o[$];
    logic [64:0] exp_r[$];
    int pkt_req[NC];
    int pkt_done[NC];
    logic gap_pending = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] rdat(input int k, input int s, input int b);
        return {40'h0, 8'(k), 8'(s), 8'(b)};
    endfunction

    function automatic logic [63:0] cdat(input logic [7:0] tag, input int i, input logic [7:0] sid);
        return {tag, 8'(i), 40'h5A5A5A5A5A, (i == 0) ? sid : 8'hEE};
    endfunction

    // Random ready for channel 0 while rnd_en is set.
    initial begin
        rnd_rdy = 1'b1;
        forever begin
            @(posedge clk); #3;
            if (rnd_en) rnd_rdy = 1'($urandom_range(0, 1));
        end
    end

    // Response sources: each packet is 2 beats; data encodes channel, packet serial, beat.
    initial begin
        logic [NC-1:0] hs;
        int seq[NC];
        int beat[NC];
        r_tvalid = '0; r_tlast = '0; r_tdata = '0;
        for (int k = 0; k < NC; k++) begin seq[k] = 0; beat[k] = 0; end
        forever begin
            @(negedge clk);
            hs = r_tvalid & r_tready;
            @(posedge clk); #2;
            for (int k = 0; k < NC; k++) begin
                if (hs[k]) begin
                    if (beat[k] == 1) begin
                        beat[k] = 0; seq[k]++; pkt_done[k]++;
                    end else beat[k]++;
                end
                r_tvalid[k]        = (pkt_req[k] > pkt_done[k]);
                r_tlast[k]         = (beat[k] == 1);
                r_tdata[k*W +: W]  = rdat(k, seq[k], beat[k]);
            end
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (o_tvalid != '0) chk("o_onehot", 128'($onehot(o_tvalid)), 1);
            for (int k = 0; k < NC; k++) begin
                if (o_tvalid[k]) begin
                    chk("o_slice_data", o_tdata[k*W +: W], ctrl_tdata);
                    chk("ctrl_tready_mirror", ctrl_tready, o_tready[k]);
                    if (o_tready[k]) begin
                        if (exp_o.size() == 0) chk("o_unexpected_beat", 1, 0);
                        else chk("o_beat", {4'(k), o_tlast[k], o_tdata[k*W +: W]}, exp_o.pop_front());
                    end
                end
            end
            if (gap_pending) begin
                chk("resp_idle_gap", resp_tvalid, 0);
                gap_pending <= 1'b0;
            end
            if (resp_tvalid && resp_tready) begin
                if (exp_r.size() == 0) chk("resp_unexpected_beat", 1, 0);
                else chk("resp_beat", {resp_tlast, resp_tdata}, exp_r.pop_front());
                if (resp_tlast) gap_pending <= 1'b1;
            end
        end
    end

    task automatic drive_beat(input logic [63:0] d, input logic l);
        int n = 0;
        ctrl_tvalid = 1'b1; ctrl_tdata = d; ctrl_tlast = l;
        @(negedge clk);
        while (!ctrl_tready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) chk("ctrl_beat_timeout", 0, 1);
        @(posedge clk); #1;
        ctrl_tvalid = 1'b0; ctrl_tlast = 1'b0;
    endtask

    // ch < 0 marks a packet expected to be dropped.
    task automatic send_pkt(input logic [7:0] sid, input int nb, input int ch,
                            input logic [7:0] tag, input bit lat);
        logic [63:0] d;
        for (int i = 0; i < nb; i++) begin
            d = cdat(tag, i, sid);
            if (ch >= 0) exp_o.push_back({4'(ch), (i == nb - 1), d});
            if (lat && i == 0) begin
                ctrl_tvalid = 1'b1; ctrl_tdata = d; ctrl_tlast = (nb == 1);
                @(negedge clk);
                chk("hdr_decode_cycle", {ctrl_tready, o_tvalid}, 0);
                @(negedge clk);
                chk("hdr_next_cycle", o_tvalid, 4'(1 << ch));
                @(posedge clk); #1;
                ctrl_tvalid = 1'b0; ctrl_tlast = 1'b0;
            end else drive_beat(d, (i == nb - 1));
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_o.size() != 0 || exp_r.size() != 0) && n < 300) begin @(negedge clk); n++; end
        chk(name, 128'(exp_o.size() + exp_r.size()), 0);
    endtask

    task automatic step;
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        reset = 1'b0; clear = 1'b0;
        ctrl_tdata = '0; ctrl_tlast = 1'b0; ctrl_tvalid = 1'b0;
        o_tready_m = '1; rnd_en = 1'b0; resp_tready = 1'b0;
        #2 reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {ctrl_tready, o_tvalid, r_tready, resp_tvalid, demux_busy}, 0);
        chk("reset_drop_count", drop_count, 0);

        // 3-beat packet to ch1 with first-beat latency check
        step();
        send_pkt(8'h31, 3, 1, 8'h01, 1'b1);
        drain("fwd_ch1_drain");

        // Unmatched 2-beat packet
        step();
        send_pkt(8'h77, 2, -1, 8'h02, 1'b0);
        @(negedge clk);
        chk("drop_count_one", drop_count, 1);

        // Random backpressure on channel 0
        step();
        rnd_en = 1'b1;
        send_pkt(8'h42, 5, 0, 8'h03, 1'b0);
        step();
        rnd_en = 1'b0;
        drain("fwd_ch0_bp_drain");

        // Single-beat packet to ch3 (0x55 masks to 0x50)
        send_pkt(8'h55, 1, 3, 8'h04, 1'b0);
        @(negedge clk);
        chk("single_beat_idle", demux_busy, 0);

        // Round-robin across all four channels with concurrent control traffic
        step();
        resp_tready = 1'b1;
        for (int s = 0; s < 2; s++)
            for (int k = 0; k < NC; k++) begin
                exp_r.push_back({1'b0, rdat(k, s, 0)});
                exp_r.push_back({1'b1, rdat(k, s, 1)});
            end
        for (int k = 0; k < NC; k++) pkt_req[k] += 2;
        send_pkt(8'h1F, 4, 2, 8'h05, 1'b0);
        drain("rr_drain");

        // Reset while forwarding to ch2 with its ready held low
        step();
        o_tready_m = '0;
        ctrl_tvalid = 1'b1; ctrl_tdata = cdat(8'h06, 0, 8'h12); ctrl_tlast = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("fwd_before_reset", {demux_busy, o_tvalid}, {1'b1, 4'b0100});
        #1 reset = 1'b1;
        #1 chk("reset_mid_packet", {o_tvalid, ctrl_tready, demux_busy}, 0);
        ctrl_tvalid = 1'b0;
        step();
        reset = 1'b0; o_tready_m = '1;
        step();

        // Drop counter saturation (CW=4 -> 15)
        for (int i = 1; i <= 18; i++) begin
            send_pkt(8'hA3, 1, -1, 8'h07, 1'b0);
            if (i == 14 || i == 15 || i == 18) begin
                @(negedge clk);
                chk("drop_count_sat", drop_count, (i == 14) ? 14 : 15);
            end
        end

        // Clear with 5 drops counted and ch2 response mid-packet, after ch1 held last grant
        clear = 1'b1; step(); clear = 1'b0;
        for (int i = 0; i < 5; i++) send_pkt(8'h77, 2, -1, 8'h08, 1'b0);
        @(negedge clk);
        chk("drop_count_five", drop_count, 5);
        step();
        exp_r.push_back({1'b0, rdat(1, 2, 0)});
        exp_r.push_back({1'b1, rdat(1, 2, 1)});
        pkt_req[1]++;
        drain("ch1_pkt_drain");
        step();
        exp_r.push_back({1'b0, rdat(2, 2, 0)});
        pkt_req[2]++;
        n = 0;
        @(negedge clk);
        while (!(resp_tvalid && resp_tready) && n < 50) begin @(negedge clk); n++; end
        chk("ch2_first_beat_seen", (n < 50), 1);
        step();
        resp_tready = 1'b0; clear = 1'b1; pkt_req[1]++;
        step();
        clear = 1'b0;
        @(negedge clk);
        chk("clear_state", {resp_tvalid, r_tready, demux_busy, drop_count}, 0);
        // last_grant back to 3 so ch1 wins over the leftover ch2 beat
        exp_r.push_back({1'b0, rdat(1, 3, 0)});
        exp_r.push_back({1'b1, rdat(1, 3, 1)});
        exp_r.push_back({1'b1, rdat(2, 2, 1)});
        step();
        resp_tready = 1'b1;
        drain("after_clear_drain");

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
